// File: rtl/mem_arb_pkg.sv
// Shared types and default sizes for the memory port arbiter.
//   arb_state_t : arbiter sequencer states
//   DEF_*       : default parameter values used by the top level
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

  localparam int DEF_N_REQ   = 4;
  localparam int DEF_ADDR_W  = 32;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_MEM_LAT = 1;

endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector.
// Scans requesters starting at last_owner+1 and wrapping modulo N_REQ.
//   req        : request vector
//   last_owner : index of the most recently served requester
//   any        : at least one request is set
//   idx        : index of the winner
//   onehot     : one-hot form of the winner
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last_owner,
  output logic             any,
  output logic [IDX_W-1:0] idx,
  output logic [N_REQ-1:0] onehot
);

  int cand;

  always_comb begin
    any    = 1'b0;
    idx    = '0;
    onehot = '0;
    cand   = 0;
    // Offset 1 is checked first, so the last owner is only picked again
    // when nobody else is asking.
    for (int k = 1; k <= N_REQ; k++) begin
      cand = (int'(last_owner) + k) % N_REQ;
      if (!any && req[cand]) begin
        any    = 1'b1;
        idx    = IDX_W'(cand);
        onehot = N_REQ'(1) << cand;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency single-port memory between
// N_REQ requesters. Requests are sampled in IDLE, issued for one cycle in
// ISSUE, reads wait MEM_LAT cycles in WAIT, and DONE pulses the owner's
// done bit (with rdata for reads).
//   clk, reset         : clock, synchronous active-high reset
//   req, we            : per-requester request level and write enable
//   addr, wdata        : packed per-requester address / write data
//   gnt                : one-hot current owner, 0 when idle
//   done               : one-cycle completion pulse to the owner
//   rdata              : last captured read data
//   mem_en, mem_we     : memory strobes, only high in ISSUE
//   mem_addr, mem_wdata: memory address / write data, 0 outside ISSUE
//   mem_rdata          : memory read data
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int N_REQ   = DEF_N_REQ,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int MEM_LAT = DEF_MEM_LAT
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ-1:0]        we,
  input  logic [N_REQ*ADDR_W-1:0] addr,
  input  logic [N_REQ*DATA_W-1:0] wdata,
  output logic [N_REQ-1:0]        gnt,
  output logic [N_REQ-1:0]        done,
  output logic [DATA_W-1:0]       rdata,
  output logic                    mem_en,
  output logic                    mem_we,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [DATA_W-1:0]       mem_wdata,
  input  logic [DATA_W-1:0]       mem_rdata
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(MEM_LAT + 1);

  arb_state_t state_q, state_d;

  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic [N_REQ-1:0]  done_q, done_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [IDX_W-1:0]  owner_q, owner_d;
  logic [IDX_W-1:0]  last_q, last_d;
  logic              lat_we_q, lat_we_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              pick_any;
  logic [IDX_W-1:0]  pick_idx;
  logic [N_REQ-1:0]  pick_onehot;
  int                sel;

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req        (req),
    .last_owner (last_q),
    .any        (pick_any),
    .idx        (pick_idx),
    .onehot     (pick_onehot)
  );

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    done_d      = '0;
    rdata_d     = rdata_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    owner_d     = owner_q;
    last_d      = last_q;
    lat_we_d    = lat_we_q;
    cnt_d       = cnt_q;
    sel         = int'(pick_idx);

    // Outputs are registered, so each case loads the values that the
    // *next* state presents.
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          owner_d     = pick_idx;
          lat_we_d    = we[sel];
          gnt_d       = pick_onehot;
          mem_en_d    = 1'b1;
          mem_we_d    = we[sel];
          mem_addr_d  = addr[sel*ADDR_W +: ADDR_W];
          mem_wdata_d = wdata[sel*DATA_W +: DATA_W];
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        if (lat_we_q) begin
          done_d  = gnt_q;
          state_d = DONE;
        end else begin
          cnt_d   = CNT_W'(MEM_LAT);
          state_d = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        // Count of 1 marks the cycle mem_rdata is valid for this access.
        if (cnt_q == CNT_W'(1)) begin
          rdata_d = mem_rdata;
          done_d  = gnt_q;
          state_d = DONE;
        end
      end
      DONE: begin
        last_d  = owner_q;
        gnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      done_q      <= '0;
      rdata_q     <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      owner_q     <= '0;
      last_q      <= IDX_W'(N_REQ - 1);
      lat_we_q    <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      done_q      <= done_d;
      rdata_q     <= rdata_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      lat_we_q    <= lat_we_d;
      cnt_q       <= cnt_d;
    end
  end

  assign gnt       = gnt_q;
  assign done      = done_q;
  assign rdata     = rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter: one instance with MEM_LAT=1
// (backed by a small memory model) and one with MEM_LAT=3 (fed a
// cycle-stamped read-data pattern), sharing the requester inputs.
module tb_mem_port_arbiter;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [3:0]   req = '0;
  logic [3:0]   we = '0;
  logic [127:0] addr = '0;
  logic [127:0] wdata = '0;

  logic [3:0]  gnt1, done1, gnt3, done3;
  logic [31:0] rdata1, rdata3;
  logic        mem_en1, mem_we1, mem_en3, mem_we3;
  logic [31:0] mem_addr1, mem_wdata1, mem_addr3, mem_wdata3;
  logic [31:0] mem_rdata1 = '0;
  logic [31:0] mem_rdata3;

  int cyc = 0;
  int passed = 0;
  int total = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Latency-1 memory: data appears the cycle after the strobe.
  always @(posedge clk)
    if (mem_en1 && !mem_we1)
      mem_rdata1 <= (mem_addr1 == 32'h40) ? 32'hDEADBEEF : (mem_addr1 ^ 32'h5A5A5A5A);

  // Value changes every cycle so the capture cycle is identifiable.
  assign mem_rdata3 = 32'hC0DE0000 | (cyc & 32'h0000FFFF);

  mem_port_arbiter #(.N_REQ(4), .ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u_dut1 (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt1), .done(done1), .rdata(rdata1), .mem_en(mem_en1), .mem_we(mem_we1),
    .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1)
  );

  mem_port_arbiter #(.N_REQ(4), .ADDR_W(32), .DATA_W(32), .MEM_LAT(3)) u_dut3 (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt3), .done(done3), .rdata(rdata3), .mem_en(mem_en3), .mem_we(mem_we3),
    .mem_addr(mem_addr3), .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req = '0;
    we = '0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (gnt1 !== 4'b0) $display("FAIL reset_gnt got=%b exp=%b", gnt1, 4'b0); else passed++;
    total++; if (done1 !== 4'b0) $display("FAIL reset_done got=%b exp=%b", done1, 4'b0); else passed++;
    total++; if (rdata1 !== 32'h0) $display("FAIL reset_rdata got=%h exp=%h", rdata1, 32'h0); else passed++;
    total++; if ({mem_en1, mem_we1} !== 2'b00) $display("FAIL reset_mem_strobes got=%b exp=%b", {mem_en1, mem_we1}, 2'b00); else passed++;
    total++; if ({mem_addr1, mem_wdata1} !== 64'h0) $display("FAIL reset_mem_bus got=%h exp=%h", {mem_addr1, mem_wdata1}, 64'h0); else passed++;
  endtask

  task automatic test_single_read_then_write();
    do_reset();
    req = 4'b0100; we = 4'b0000; addr[2*32 +: 32] = 32'h40;
    step(); // t+1
    total++; if (gnt1 !== 4'b0100) $display("FAIL rd_gnt got=%b exp=%b", gnt1, 4'b0100); else passed++;
    total++; if ({mem_en1, mem_we1} !== 2'b10) $display("FAIL rd_mem_strobes got=%b exp=%b", {mem_en1, mem_we1}, 2'b10); else passed++;
    total++; if (mem_addr1 !== 32'h40) $display("FAIL rd_mem_addr got=%h exp=%h", mem_addr1, 32'h40); else passed++;
    step(); // t+2
    total++; if ({mem_en1, done1} !== 5'b0) $display("FAIL rd_t2_quiet got=%b exp=%b", {mem_en1, done1}, 5'b0); else passed++;
    step(); // t+3
    total++; if (done1 !== 4'b0100) $display("FAIL rd_done got=%b exp=%b", done1, 4'b0100); else passed++;
    total++; if (rdata1 !== 32'hDEADBEEF) $display("FAIL rd_rdata got=%h exp=%h", rdata1, 32'hDEADBEEF); else passed++;
    req = 4'b0000;
    step(); // t+4, back in IDLE
    total++; if ({gnt1, done1} !== 8'h00) $display("FAIL rd_idle got=%h exp=%h", {gnt1, done1}, 8'h00); else passed++;

    req = 4'b0010; we = 4'b0010; addr[1*32 +: 32] = 32'h10; wdata[1*32 +: 32] = 32'h1234;
    step(); // t+1
    total++; if (gnt1 !== 4'b0010) $display("FAIL wr_gnt got=%b exp=%b", gnt1, 4'b0010); else passed++;
    total++; if ({mem_en1, mem_we1} !== 2'b11) $display("FAIL wr_mem_strobes got=%b exp=%b", {mem_en1, mem_we1}, 2'b11); else passed++;
    total++; if ({mem_addr1, mem_wdata1} !== {32'h10, 32'h1234}) $display("FAIL wr_mem_bus got=%h exp=%h", {mem_addr1, mem_wdata1}, {32'h10, 32'h1234}); else passed++;
    step(); // t+2
    total++; if (done1 !== 4'b0010) $display("FAIL wr_done got=%b exp=%b", done1, 4'b0010); else passed++;
    total++; if (mem_en1 !== 1'b0) $display("FAIL wr_mem_en_drop got=%b exp=%b", mem_en1, 1'b0); else passed++;
    total++; if (rdata1 !== 32'hDEADBEEF) $display("FAIL wr_rdata_held got=%h exp=%h", rdata1, 32'hDEADBEEF); else passed++;
    req = 4'b0000; we = 4'b0000;
    step(); // t+3
    total++; if ({gnt1, done1} !== 8'h00) $display("FAIL wr_idle got=%h exp=%h", {gnt1, done1}, 8'h00); else passed++;
  endtask

  task automatic test_round_robin();
    logic [3:0]  eg;
    logic [31:0] ea;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      addr[i*32 +: 32]  = 32'h100 * (i + 1);
      wdata[i*32 +: 32] = 32'hA0 + i;
    end
    req = 4'b1111; we = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      eg = 4'b0001 << (k % 4);
      ea = 32'h100 * ((k % 4) + 1);
      step();
      total++; if (gnt1 !== eg) $display("FAIL rr_gnt_%0d got=%b exp=%b", k, gnt1, eg); else passed++;
      total++; if (mem_addr1 !== ea) $display("FAIL rr_addr_%0d got=%h exp=%h", k, mem_addr1, ea); else passed++;
      total++; if (gnt3 !== eg) $display("FAIL rr3_gnt_%0d got=%b exp=%b", k, gnt3, eg); else passed++;
      step();
      total++; if (done1 !== eg) $display("FAIL rr_done_%0d got=%b exp=%b", k, done1, eg); else passed++;
      step();
    end
    req = 4'b0000; we = 4'b0000;
  endtask

  task automatic test_latency3();
    int          c0;
    logic [31:0] er;
    do_reset();
    req = 4'b0001; we = 4'b0000; addr[0 +: 32] = 32'h80;
    c0 = cyc;
    er = 32'hC0DE0000 | ((c0 + 4) & 32'h0000FFFF);
    step(); // t+1
    total++; if ({gnt3, mem_en3} !== 5'b00011) $display("FAIL l3_issue got=%b exp=%b", {gnt3, mem_en3}, 5'b00011); else passed++;
    for (int k = 2; k <= 4; k++) begin
      step();
      total++; if ({done3, mem_en3} !== 5'b0) $display("FAIL l3_wait_t%0d got=%b exp=%b", k, {done3, mem_en3}, 5'b0); else passed++;
    end
    step(); // t+5
    total++; if (done3 !== 4'b0001) $display("FAIL l3_done got=%b exp=%b", done3, 4'b0001); else passed++;
    total++; if (rdata3 !== er) $display("FAIL l3_rdata got=%h exp=%h", rdata3, er); else passed++;
    req = 4'b0000;
    step();
    total++; if ({gnt3, done3} !== 8'h00) $display("FAIL l3_idle got=%h exp=%h", {gnt3, done3}, 8'h00); else passed++;
  endtask

  task automatic test_reset_in_wait();
    do_reset();
    req = 4'b1000; we = 4'b0000; addr[3*32 +: 32] = 32'h300;
    step(); // ISSUE
    total++; if (gnt3 !== 4'b1000) $display("FAIL rw_gnt got=%b exp=%b", gnt3, 4'b1000); else passed++;
    step(); // WAIT
    reset = 1'b1;
    step();
    total++; if ({gnt3, done3, mem_en3} !== 9'b0) $display("FAIL rw_abort got=%b exp=%b", {gnt3, done3, mem_en3}, 9'b0); else passed++;
    reset = 1'b0;
    req = 4'b1001; addr[0 +: 32] = 32'h0;
    step();
    total++; if (gnt3 !== 4'b0001) $display("FAIL rw_first_after_reset got=%b exp=%b", gnt3, 4'b0001); else passed++;
    for (int k = 2; k <= 4; k++) begin
      step();
      total++; if (done3 !== 4'b0000) $display("FAIL rw_no_done_t%0d got=%b exp=%b", k, done3, 4'b0000); else passed++;
    end
    step();
    total++; if (done3 !== 4'b0001) $display("FAIL rw_done0 got=%b exp=%b", done3, 4'b0001); else passed++;
    req = 4'b0000;
  endtask

  task automatic test_drop_req();
    do_reset();
    req = 4'b1000; we = 4'b0000; addr[3*32 +: 32] = 32'h30;
    step(); // ISSUE
    total++; if (gnt1 !== 4'b1000) $display("FAIL dr_gnt got=%b exp=%b", gnt1, 4'b1000); else passed++;
    step(); // WAIT
    req = 4'b0000;
    step(); // DONE
    total++; if (done1 !== 4'b1000) $display("FAIL dr_done got=%b exp=%b", done1, 4'b1000); else passed++;
    total++; if (rdata1 !== 32'h5A5A5A6A) $display("FAIL dr_rdata got=%h exp=%h", rdata1, 32'h5A5A5A6A); else passed++;
    step(); // IDLE
    step();
    total++; if ({gnt1, mem_en1, done1} !== 9'b0) $display("FAIL dr_no_regrant got=%b exp=%b", {gnt1, mem_en1, done1}, 9'b0); else passed++;
  endtask

  initial begin
    test_reset();
    test_single_read_then_write();
    test_round_robin();
    test_latency3();
    test_reset_in_wait();
    test_drop_req();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
